// File: rtl/uart_tx_engine.sv
// UART transmit control engine: latches a byte, builds the 11-bit serial frame
// and sequences the load/shift strobes for the downstream shift register.
module uart_tx_engine #(
   parameter int BT_W    = 19,
   parameter int FRAME_W = 11
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               write,
   input  logic [7:0]         data_in,
   input  logic               eight,
   input  logic               pen,
   input  logic               ohel,
   input  logic [BT_W-1:0]    bit_time,
   output logic [FRAME_W-1:0] frame_out,
   output logic               load,
   output logic               shift,
   output logic               tx_ready,
   output logic               tx_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   localparam logic [3:0]      LAST_BIT = 4'd10;
   localparam logic [BT_W-1:0] BT_ONE   = {{(BT_W-1){1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [BT_W-1:0]    bt_q, bt_d;
   logic [BT_W-1:0]    bt_cnt_q, bt_cnt_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic               bit_end_s;

   function automatic logic parity_f(input logic [7:0] d, input logic [7:0] mask,
                                     input logic odd);
      return (^(d & mask)) ^ odd;
   endfunction

   // Bit 0 is the start bit; everything above the data/parity field is stop padding.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d, input logic e,
                                                      input logic p, input logic o);
      logic [FRAME_W-1:0] f;
      f      = {FRAME_W{1'b1}};
      f[0]   = 1'b0;
      f[7:1] = d[6:0];
      if (e) begin
         f[8] = d[7];
         f[9] = p ? parity_f(d, 8'hFF, o) : 1'b1;
      end else begin
         f[8] = p ? parity_f(d, 8'h7F, o) : 1'b1;
      end
      return f;
   endfunction

   assign bit_end_s = (state_q == SEND) && (bt_cnt_q == (bt_q - BT_ONE));

   assign frame_out = frame_q;
   assign load      = (state_q == LOAD);
   assign tx_ready  = (state_q == IDLE);
   assign shift     = bit_end_s && (bit_cnt_q != LAST_BIT);
   assign tx_done   = bit_end_s && (bit_cnt_q == LAST_BIT);

   // Next-state and datapath decode for the IDLE -> LOAD -> SEND sequence.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bt_d      = bt_q;
      bt_cnt_d  = bt_cnt_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            if (write) begin
               state_d = LOAD;
               frame_d = build_frame(data_in, eight, pen, ohel);
               bt_d    = (bit_time == {BT_W{1'b0}}) ? BT_ONE : bit_time;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            state_d   = SEND;
            bt_cnt_d  = {BT_W{1'b0}};
            bit_cnt_d = 4'd0;
         end
         SEND: begin
            if (bit_end_s) begin
               bt_cnt_d = {BT_W{1'b0}};
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               bt_cnt_d = bt_cnt_q + BT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any frame in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         frame_q   <= {FRAME_W{1'b1}};
         bt_q      <= BT_ONE;
         bt_cnt_q  <= {BT_W{1'b0}};
         bit_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bt_q      <= bt_d;
         bt_cnt_q  <= bt_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a per-frame cycle-schedule model is
// compared against the DUT on every falling edge, plus directed literal frames.
module tb_uart_tx_engine;

   localparam int BT_W = 19;

   logic            clock = 1'b0;
   logic            reset;
   logic            write;
   logic [7:0]      data_in;
   logic            eight, pen, ohel;
   logic [BT_W-1:0] bit_time;
   logic [10:0]     frame_out;
   logic            load, shift, tx_ready, tx_done;

   int n_cmp = 0;
   int n_bad = 0;

   // model: one frame = a load cycle followed by 11 bit times
   bit          m_busy  = 1'b0;
   int          m_c     = 0;
   int          m_bt    = 1;
   logic [10:0] m_frame = 11'h7FF;

   uart_tx_engine #(.BT_W(BT_W), .FRAME_W(11)) dut (
      .clock(clock), .reset(reset), .write(write), .data_in(data_in),
      .eight(eight), .pen(pen), .ohel(ohel), .bit_time(bit_time),
      .frame_out(frame_out), .load(load), .shift(shift),
      .tx_ready(tx_ready), .tx_done(tx_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic e,
                                             input logic p, input logic o);
      int          n   = e ? 8 : 7;
      logic [10:0] f   = 11'h7FF;
      logic        par = o;
      f[0] = 1'b0;
      for (int i = 0; i < n; i++) begin
         f[i+1] = d[i];
         par    = par ^ d[i];
      end
      if (p) f[n+1] = par;
      return f;
   endfunction

   function automatic int last_cycle();
      return 1 + 11 * m_bt;
   endfunction

   task automatic model_step();
      if (!reset) begin
         m_busy  = 1'b0;
         m_frame = 11'h7FF;
      end else if (!m_busy) begin
         if (write) begin
            m_busy  = 1'b1;
            m_c     = 1;
            m_bt    = (bit_time == 0) ? 1 : int'(bit_time);
            m_frame = exp_frame(data_in, eight, pen, ohel);
         end
      end else if (m_c == last_cycle()) begin
         m_busy = 1'b0;
      end else begin
         m_c++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   // Compare every output against the model each falling edge.
   always @(negedge clock) begin
      logic e_load, e_shift, e_done;
      e_load  = m_busy && (m_c == 1);
      e_shift = m_busy && (m_c > 1) && ((m_c - 1) % m_bt == 0) && (m_c < last_cycle());
      e_done  = m_busy && (m_c == last_cycle());
      chk("frame_out", frame_out, m_frame);
      chk("tx_ready", tx_ready, !m_busy);
      chk("load", load, e_load);
      chk("shift", shift, e_shift);
      chk("tx_done", tx_done, e_done);
   end

   task automatic run_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                            input int bt, input logic [10:0] lit, input int len, input bit poke);
      int n;
      write = 1'b1; data_in = d; eight = e; pen = p; ohel = o; bit_time = BT_W'(bt);
      tick();
      write = 1'b0;
      chk("frame_lit", frame_out, lit);
      chk("load_lit", load, 1'b1);
      n = 1;
      while (tx_done !== 1'b1 && n < 600) begin
         if (poke && n == 10) begin
            write = 1'b1; data_in = 8'h12; bit_time = BT_W'(7); eight = ~e;
         end else begin
            write = 1'b0;
         end
         tick();
         n++;
      end
      chk("frame_len", n, len);
      if (poke) begin
         write = 1'b1; data_in = 8'h12;
      end
      tick();
      write = 1'b0;
      chk("ready_after", tx_ready, 1'b1);
      chk("frame_hold", frame_out, lit);
   endtask

   initial begin
      reset = 1'b0; write = 1'b0; data_in = 8'h00; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
      bit_time = '0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("idle_frame", frame_out, 11'h7FF);

      run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 4, 11'h54A, 45, 1'b1);
      run_frame(8'h41, 1'b0, 1'b0, 1'b0, 0, 11'h782, 12, 1'b0);
      run_frame(8'h43, 1'b0, 1'b1, 1'b1, 1, 11'h686, 12, 1'b0);
      run_frame(8'h43, 1'b0, 1'b1, 1'b0, 3, 11'h786, 34, 1'b0);

      // abort during bit 5 of a bit_time=4 frame
      write = 1'b1; data_in = 8'h5A; eight = 1'b1; pen = 1'b0; ohel = 1'b0; bit_time = BT_W'(4);
      tick();
      write = 1'b0;
      repeat (22) tick();
      #1 reset = 1'b0;
      #1;
      m_busy = 1'b0; m_frame = 11'h7FF;
      chk("rst_frame", frame_out, 11'h7FF);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_load", load, 1'b0);
      chk("rst_shift", shift, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 4, 11'h54A, 45, 1'b0);

      for (int i = 0; i < 1500; i++) begin
         write    = ($urandom_range(0, 3) == 0);
         data_in  = 8'($urandom);
         eight    = 1'($urandom);
         pen      = 1'($urandom);
         ohel     = 1'($urandom);
         bit_time = BT_W'($urandom_range(0, 3));
         tick();
      end
      write = 1'b0;
      for (int i = 0; i < 100 && m_busy; i++) tick();
      chk("final_idle", tx_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Transmit control engine feeding the UART TX shift register stage. It accepts a byte from the processor-side write strobe and builds the 11-bit serial frame (start, data, optional parity, stop padding). It then drives the load/shift strobes at the programmed bit time. It flags ready and done so the processor can queue the next byte.

Parameters:
BT_W, 19, width of bit_time input and bit-time counter
FRAME_W, 11, frame length in bits (fixed at 11; not intended to be overridden)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
write  input  1  one-cycle strobe; request to transmit data_in
data_in  input  8  byte to transmit
eight  input  1  1 = 8 data bits, 0 = 7 data bits (data_in[7] ignored)
pen  input  1  parity enable
ohel  input  1  parity sense: 1 = odd, 0 = even
bit_time  input  BT_W  clocks per serial bit; 0 treated as 1
frame_out  output  11  frame to shift register data_in, LSB first on line
load  output  1  one-cycle load strobe to shift register
shift  output  1  one-cycle shift strobe to shift register
tx_ready  output  1  level; 1 = idle, write will be accepted
tx_done  output  1  one-cycle pulse in last clock of final bit time

Behaviour:
- Reset (reset==0, async): frame_out=11'h7FF, load=0, shift=0, tx_ready=1, tx_done=0, bit-time and bit counters=0, state IDLE. Reset mid-frame aborts the frame immediately; no done pulse is issued.
- States: IDLE -> LOAD -> SEND -> IDLE.
- IDLE: tx_ready=1. If write=1 at an edge, latch data_in, eight, pen, ohel, bit_time (0->1) and compute frame_out. Go to LOAD; tx_ready falls the same edge.
- LOAD: load=1 for exactly one cycle, frame_out stable. Shift register captures at the next edge; start bit appears on the line from that edge. Then go to SEND with bt_cnt=0, bit_cnt=0.
- SEND: bt_cnt increments each clock. When bt_cnt==bit_time-1:
  - bt_cnt wraps to 0.
  - If bit_cnt<10: shift=1 that cycle (combinational decode), and bit_cnt increments.
  - If bit_cnt==10: no shift; tx_done=1 that cycle; next edge enters IDLE with tx_ready=1.
- Every bit occupies exactly bit_time clocks. Load cycle to end of tx_done cycle totals 1 + 11*bit_time clocks.
- Frame composition, bit 0 first; start bit is always 0 and padding/stop bits are 1:
  - eight=0, pen=0: {1,1,1,d[6:0],0}
  - eight=0, pen=1: {1,1,p7,d[6:0],0}
  - eight=1, pen=0: {1,1,d[7:0],0}
  - eight=1, pen=1: {1,p8,d[7:0],0}
- Parity: p7 = ^d[6:0] ^ ohel; p8 = ^d[7:0] ^ ohel.
- Writes while tx_ready=0, including the tx_done cycle, are ignored and have no side effects.
- Input changes to config/data/bit_time during a frame have no effect until the next accepted write.
- shift and load are never high in the same cycle.

Test Plan:
- Reset and idle: hold reset=0, then release -> frame_out=0x7FF, tx_ready=1, load=shift=tx_done=0; no strobes while idle.
- 8-bit even parity: bit_time=4, data_in=0xA5, eight=1, pen=1, ohel=0, write pulse -> frame_out=0x54A, load high 1 cycle; 10 shift pulses spaced 4 clocks; tx_done at clock 45 counted from the load cycle as clock 1; tx_ready high next edge.
- 7-bit variants: data 0x41, eight=0, pen=0 -> 0x782. Data 0x43, eight=0, pen=1, ohel=1 -> 0x686. Data 0x43, eight=0, pen=1, ohel=0 -> 0x786.
- Busy write and back-to-back: write 0x12 mid-frame and again on the tx_done cycle -> both ignored. Write the cycle after tx_ready rises -> accepted, new load.
- bit_time=0 and bit_time=1: shift asserted every clock for 10 cycles; total frame = 12 clocks.
- Reset mid-frame: reset low during bit 5 -> outputs return to reset values asynchronously; no tx_done; a new write after release transmits a correct full frame.
